packet_receiver: RTL and testbench



---
 rtl/packet_receiver.sv | 146 ++++++++++++++
 tb/tb_packet_receiver.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_receiver.sv
// Packet receiver: parses src/dest/size/data/crc bytes into one fifo slot, commits the slot with winc on the crc byte.
// Latency: each accepted byte appears on waddr_in/wdata one clock later. Backpressure: none; wfull is checked on the first byte only.
module packet_receiver #(
  parameter int UWIDTH    = 8,
  parameter int PTR_IN_SZ = 4,
  parameter int MAX_DSZ   = 12,
  parameter int TIMEOUT   = 16,
  parameter int CRC_CHECK = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 packet_valid,
  input  logic [UWIDTH-1:0]    packet_in,
  input  logic                 wfull,
  output logic                 winc,
  output logic [PTR_IN_SZ-1:0] waddr_in,
  output logic [UWIDTH-1:0]    wdata,
  output logic                 busy,
  output logic                 pkt_done,
  output logic                 pkt_err,
  output logic [1:0]           err_code
);

  typedef enum logic [2:0] {IDLE, SRC, SIZE, DATA, CRC, DROP_HDR, DROP} state_t;

  localparam logic [UWIDTH-1:0] MAX_SZ  = UWIDTH'(MAX_DSZ);
  localparam logic [UWIDTH:0]   REM_ONE = (UWIDTH+1)'(1);
  localparam logic [15:0]       TO_LAST = 16'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state;
  logic [UWIDTH:0]   remaining;   // one bit wider: a dropped packet may need size+1 bytes
  logic              hdr_cnt;
  logic [UWIDTH-1:0] crc_acc;
  logic [15:0]       idle_cnt;
  logic              timeout_hit;

  assign busy        = (state != IDLE);
  assign timeout_hit = (TIMEOUT != 0) && !packet_valid && (state != IDLE) && (idle_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      hdr_cnt   <= 1'b0;
      crc_acc   <= '0;
      idle_cnt  <= '0;
      winc      <= 1'b0;
      waddr_in  <= '0;
      wdata     <= '0;
      pkt_done  <= 1'b0;
      pkt_err   <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      winc     <= 1'b0;
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
      if (packet_valid)
        idle_cnt <= '0;
      else if (state != IDLE)
        idle_cnt <= idle_cnt + 1'b1;

      if (timeout_hit) begin
        state    <= IDLE;
        pkt_err  <= 1'b1;
        err_code <= 2'd3;
        crc_acc  <= '0;
        idle_cnt <= '0;
      end else if (packet_valid) begin
        case (state)
          IDLE: begin
            waddr_in <= '0;
            wdata    <= packet_in;
            crc_acc  <= packet_in;
            if (wfull) begin
              state    <= DROP_HDR;
              hdr_cnt  <= 1'b0;
              err_code <= 2'd1;
            end else begin
              state <= SRC;
            end
          end
          SRC: begin
            waddr_in <= waddr_in + 1'b1;
            wdata    <= packet_in;
            crc_acc  <= crc_acc ^ packet_in;
            state    <= SIZE;
          end
          SIZE: begin
            waddr_in <= waddr_in + 1'b1;
            wdata    <= packet_in;
            crc_acc  <= crc_acc ^ packet_in;
            if (packet_in > MAX_SZ) begin
              state     <= DROP;
              remaining <= {1'b0, packet_in} + REM_ONE;
              err_code  <= 2'd2;
            end else if (packet_in == '0) begin
              state <= CRC;
            end else begin
              state     <= DATA;
              remaining <= {1'b0, packet_in};
            end
          end
          DATA: begin
            waddr_in  <= waddr_in + 1'b1;
            wdata     <= packet_in;
            crc_acc   <= crc_acc ^ packet_in;
            remaining <= remaining - 1'b1;
            if (remaining == REM_ONE)
              state <= CRC;
          end
          CRC: begin
            waddr_in <= waddr_in + 1'b1;
            wdata    <= packet_in;
            crc_acc  <= '0;
            state    <= IDLE;
            if ((CRC_CHECK != 0) && (packet_in != crc_acc)) begin
              pkt_err  <= 1'b1;
              err_code <= 2'd3;
            end else begin
              winc     <= 1'b1;
              pkt_done <= 1'b1;
            end
          end
          DROP_HDR: begin
            if (hdr_cnt) begin
              remaining <= {1'b0, packet_in} + REM_ONE;
              state     <= DROP;
            end else begin
              hdr_cnt <= 1'b1;
            end
          end
          DROP: begin
            remaining <= remaining - 1'b1;
            if (remaining == REM_ONE) begin
              pkt_err <= 1'b1;
              crc_acc <= '0;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_packet_receiver.sv
// Directed bench for packet_receiver: expected writes and pulses are queued by the stimulus and consumed by a monitor.
module tb_packet_receiver;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
    logic       winc;
  } wr_t;

  typedef struct packed {
    logic       done;
    logic [1:0] code;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       packet_valid = 1'b0;
  logic [7:0] packet_in = 8'd0;
  logic       wfull = 1'b0;
  logic       sel = 1'b0;

  logic       valid0, valid1;
  logic       winc0, winc1, busy0, busy1, done0, done1, err0, err1;
  logic [3:0] waddr0, waddr1;
  logic [7:0] wdata0, wdata1;
  logic [1:0] code0, code1;

  logic       o_winc, o_busy, o_done, o_err;
  logic [3:0] o_waddr;
  logic [7:0] o_wdata;
  logic [1:0] o_code;

  int vectors = 0;
  int miscompares = 0;

  wr_t        wq[$];
  ev_t        eq[$];
  logic [7:0] pq[$];
  logic [11:0] prev;

  always #5 clk = ~clk;

  assign valid0 = packet_valid & ~sel;
  assign valid1 = packet_valid & sel;

  packet_receiver u_dut (
    .clk(clk), .rst(rst), .packet_valid(valid0), .packet_in(packet_in), .wfull(wfull),
    .winc(winc0), .waddr_in(waddr0), .wdata(wdata0), .busy(busy0),
    .pkt_done(done0), .pkt_err(err0), .err_code(code0)
  );

  packet_receiver #(.TIMEOUT(4), .CRC_CHECK(1)) u_chk (
    .clk(clk), .rst(rst), .packet_valid(valid1), .packet_in(packet_in), .wfull(wfull),
    .winc(winc1), .waddr_in(waddr1), .wdata(wdata1), .busy(busy1),
    .pkt_done(done1), .pkt_err(err1), .err_code(code1)
  );

  assign o_winc  = sel ? winc1  : winc0;
  assign o_busy  = sel ? busy1  : busy0;
  assign o_done  = sel ? done1  : done0;
  assign o_err   = sel ? err1   : err0;
  assign o_waddr = sel ? waddr1 : waddr0;
  assign o_wdata = sel ? wdata1 : wdata0;
  assign o_code  = sel ? code1  : code0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input int act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0d expected nothing at %0t", name, act, $time);
  endtask

  task automatic exp_wr(input int a, input int d, input bit w);
    wr_t t;
    t.addr = 4'(a);
    t.data = 8'(d);
    t.winc = w;
    wq.push_back(t);
  endtask

  task automatic exp_ev(input bit done, input int code);
    ev_t e;
    e.done = done;
    e.code = 2'(code);
    eq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int b);
    packet_valid = 1'b1;
    packet_in    = 8'(b);
    @(posedge clk);
    #1;
    packet_valid = 1'b0;
  endtask

  // Well-formed packet from pq, expected to be committed on its last byte.
  task automatic send_good();
    exp_ev(1'b1, 0);
    for (int i = 0; i < pq.size(); i++) begin
      exp_wr(i, int'(pq[i]), i == pq.size() - 1);
      send(int'(pq[i]));
    end
  endtask

  always @(negedge clk) begin
    wr_t w;
    ev_t e;
    if (rst) begin
      prev = {o_waddr, o_wdata};
    end else begin
      if ({o_waddr, o_wdata} != prev) begin
        prev = {o_waddr, o_wdata};
        if (wq.size() == 0) begin
          fail("unexpected_write_addr", int'(o_waddr));
        end else begin
          w = wq.pop_front();
          check("waddr_in", int'(o_waddr), int'(w.addr));
          check("wdata", int'(o_wdata), int'(w.data));
          check("winc", int'(o_winc), int'(w.winc));
        end
      end else if (o_winc) begin
        fail("winc_without_write", int'(o_waddr));
      end
      if (o_done || o_err) begin
        if (eq.size() == 0) begin
          fail("unexpected_pulse_err", int'(o_err));
        end else begin
          e = eq.pop_front();
          check("pkt_done", int'(o_done), int'(e.done));
          check("pkt_err", int'(o_err), int'(!e.done));
          if (!e.done) check("err_code", int'(o_code), int'(e.code));
        end
      end
    end
  end

  initial begin
    idle(3);
    check("rst_waddr", int'(o_waddr), 0);
    check("rst_wdata", int'(o_wdata), 0);
    check("rst_winc", int'(o_winc), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_err", int'(o_err), 0);
    check("rst_code", int'(o_code), 0);
    rst = 1'b0;
    idle(1);

    pq = '{8'd10, 8'd160, 8'd3, 8'd0, 8'd1, 8'd2, 8'd15};
    send_good();
    check("busy_after_pkt1", int'(o_busy), 0);

    // Three idle cycles after the fourth byte; state and outputs must hold.
    pq = '{8'd100, 8'd10, 8'd4, 8'd0, 8'd1, 8'd2, 8'd3, 8'd55};
    exp_ev(1'b1, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        idle(3);
        check("gap_busy", int'(o_busy), 1);
        check("gap_waddr", int'(o_waddr), 3);
        check("gap_wdata", int'(o_wdata), 0);
      end
      exp_wr(i, int'(pq[i]), i == 7);
      send(int'(pq[i]));
    end

    pq = '{8'd5, 8'd6, 8'd0, 8'd9};
    send_good();

    // Oversize: header written, 14 more bytes swallowed, then a clean packet.
    exp_wr(0, 20, 1'b0);
    exp_wr(1, 21, 1'b0);
    exp_wr(2, 13, 1'b0);
    exp_ev(1'b0, 2);
    send(20);
    send(21);
    send(13);
    for (int i = 0; i < 14; i++) send(100 + i);
    check("busy_after_oversize", int'(o_busy), 0);
    pq = '{8'd30, 8'd31, 8'd1, 8'd7, 8'd99};
    send_good();

    // Fifo full on the first byte: whole packet consumed, only word 0 written.
    exp_wr(0, 40, 1'b0);
    exp_ev(1'b0, 1);
    wfull = 1'b1;
    send(40);
    wfull = 1'b0;
    send(41);
    send(2);
    send(1);
    send(2);
    send(3);
    check("busy_after_full_drop", int'(o_busy), 0);

    // Reset in the middle of DATA drops the partial packet silently.
    exp_wr(0, 50, 1'b0);
    exp_wr(1, 51, 1'b0);
    exp_wr(2, 5, 1'b0);
    exp_wr(3, 1, 1'b0);
    exp_wr(4, 2, 1'b0);
    send(50);
    send(51);
    send(5);
    send(1);
    send(2);
    idle(1);
    rst = 1'b1;
    idle(2);
    check("midrst_waddr", int'(o_waddr), 0);
    check("midrst_wdata", int'(o_wdata), 0);
    check("midrst_busy", int'(o_busy), 0);
    check("midrst_code", int'(o_code), 0);
    rst = 1'b0;
    pq = '{8'd60, 8'd61, 8'd1, 8'd8, 8'd77};
    send_good();
    idle(2);

    // Second instance: CRC_CHECK=1, TIMEOUT=4.
    rst = 1'b1;
    sel = 1'b1;
    idle(2);
    rst = 1'b0;
    pq = '{8'd10, 8'd160, 8'd3, 8'd0, 8'd1, 8'd2, 8'd170};
    send_good();

    pq = '{8'd10, 8'd160, 8'd3, 8'd0, 8'd1, 8'd2, 8'd15};
    exp_ev(1'b0, 3);
    for (int i = 0; i < 7; i++) begin
      exp_wr(i, int'(pq[i]), 1'b0);
      send(int'(pq[i]));
    end

    exp_wr(0, 11, 1'b0);
    exp_wr(1, 12, 1'b0);
    exp_wr(2, 3, 1'b0);
    exp_wr(3, 1, 1'b0);
    exp_ev(1'b0, 3);
    send(11);
    send(12);
    send(3);
    send(1);
    idle(3);
    check("timeout_busy_3", int'(o_busy), 1);
    idle(1);
    check("timeout_busy_4", int'(o_busy), 0);

    idle(3);
    check("writes_left", wq.size(), 0);
    check("pulses_left", eq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
